// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   OPERAND_W : default operand width
//   PRODUCT_W : default product width (2 * OPERAND_W)
//   state_e   : multiplier control states
package mult_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned PRODUCT_W = 2 * OPERAND_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH,
    DONE
  } state_e;

endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's-complement negate.
// On the input side this yields a magnitude when neg_i is the operand sign bit.
// On the output side it applies the product sign.
//   din_i  : W-bit value
//   neg_i  : 1 = negate, 0 = pass through
//   dout_o : W-bit result (unsigned magnitude of -2^(W-1) is 2^(W-1))
module twos_abs_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din_i,
  input  logic         neg_i,
  output logic [W-1:0] dout_o
);

  always_comb begin
    dout_o = neg_i ? (~din_i + W'(1)) : din_i;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one partial product per clock.
// The core takes WIDTH+2 cycles from start to the next acceptable start.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   start   : multiply request, accepted in IDLE or DONE
//   a, b    : operands, sampled on the accepting edge only
//   busy    : high in RUN and FINISH
//   done    : one-cycle pulse, product valid from this cycle on
//   product : 2*WIDTH-bit result, held until the next done
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = OPERAND_W,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW    = 2 * WIDTH;
  // One extra bit so the terminal count value cannot wrap.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic [PW-1:0]      product_q, product_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [PW-1:0]      prod_signed;
  logic [PW-1:0]      addend;
  logic               load;

  // Unsigned mode passes operands through untouched.
  assign sign_a = SIGNED ? a[WIDTH-1] : 1'b0;
  assign sign_b = SIGNED ? b[WIDTH-1] : 1'b0;

  twos_abs_neg #(
    .W (WIDTH)
  ) u_abs_a (
    .din_i  (a),
    .neg_i  (sign_a),
    .dout_o (abs_a)
  );

  twos_abs_neg #(
    .W (WIDTH)
  ) u_abs_b (
    .din_i  (b),
    .neg_i  (sign_b),
    .dout_o (abs_b)
  );

  twos_abs_neg #(
    .W (PW)
  ) u_neg_prod (
    .din_i  (acc_q),
    .neg_i  (neg_q),
    .dout_o (prod_signed)
  );

  // Product of two WIDTH-bit magnitudes fits in PW bits, so no overflow.
  assign addend = {{WIDTH{1'b0}}, mag_a_q} << count_q;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    done_d    = 1'b0;
    product_d = product_q;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = start;
      end
      RUN: begin
        if (mag_b_q[0]) begin
          acc_d = acc_q + addend;
        end
        mag_b_d = mag_b_q >> 1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        product_d = prod_signed;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Back-to-back start is accepted here just like in IDLE.
        load    = start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      mag_a_d = abs_a;
      mag_b_d = abs_b;
      neg_d   = sign_a ^ sign_b;
      acc_d   = '0;
      count_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == FINISH);
  assign done    = done_q;
  assign product = product_q;

endmodule
